mem_d_arbiter2: RTL and testbench

Two-requester arbiter sharing one data-memory port (mem_d_* protocol of riscv_core) between two masters, e.g. the core's data port and a DMA/debug master. Round-robin grant, request held stable until the downstream accepts, and an in-order tracking FIFO that routes each ack/error back to the master that issued it. Sits between the masters and the data cache/memory subsystem.

---
 rtl/mem_d_arbiter2.sv | 166 ++++++++++++++++
 tb/tb_mem_d_arbiter2.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_d_arbiter2.sv
// rtl/mem_d_arbiter2.sv - two-master round-robin arbiter for the mem_d data port
// In-order id FIFO routes each downstream ack/error back to the issuing master.
module mem_d_arbiter2 #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_wr_i,
  input  logic        m0_rd_i,
  input  logic [3:0]  m0_wr_i,
  input  logic        m0_cacheable_i,
  input  logic [10:0] m0_req_tag_i,
  output logic        m0_accept_o,
  output logic        m0_ack_o,
  output logic        m0_error_o,
  output logic [31:0] m0_data_rd_o,
  output logic [10:0] m0_resp_tag_o,

  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_wr_i,
  input  logic        m1_rd_i,
  input  logic [3:0]  m1_wr_i,
  input  logic        m1_cacheable_i,
  input  logic [10:0] m1_req_tag_i,
  output logic        m1_accept_o,
  output logic        m1_ack_o,
  output logic        m1_error_o,
  output logic [31:0] m1_data_rd_o,
  output logic [10:0] m1_resp_tag_o,

  output logic [31:0] mem_d_addr_o,
  output logic [31:0] mem_d_data_wr_o,
  output logic        mem_d_rd_o,
  output logic [3:0]  mem_d_wr_o,
  output logic        mem_d_cacheable_o,
  output logic [10:0] mem_d_req_tag_o,
  input  logic        mem_d_accept_i,
  input  logic        mem_d_ack_i,
  input  logic        mem_d_error_i,
  input  logic [31:0] mem_d_data_rd_i,
  input  logic [10:0] mem_d_resp_tag_i,

  output logic        unexpected_ack_o
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(OUTSTANDING);

  logic          rr_q, rr_d;
  logic          lock_q, lock_d;
  logic          lock_id_q, lock_id_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          unexp_q, unexp_d;
  logic          fifo_q [OUTSTANDING];

  logic m0_active, m1_active;
  logic sel, sel_active, full, req_valid, push, pop, head;

  assign m0_active = m0_rd_i | (|m0_wr_i);
  assign m1_active = m1_rd_i | (|m1_wr_i);

  // A stalled request stays locked to its master so the downstream view is stable.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (rr_q ? m1_active : m0_active) begin
      sel = rr_q;
    end else begin
      sel = ~rr_q;
    end
  end

  assign sel_active = sel ? m1_active : m0_active;
  assign full       = (count_q == FULL);
  assign req_valid  = sel_active & ~full;
  assign push       = req_valid & mem_d_accept_i;
  assign pop        = mem_d_ack_i & (count_q != '0);
  assign head       = fifo_q[rd_ptr_q];

  assign mem_d_addr_o      = sel ? m1_addr_i      : m0_addr_i;
  assign mem_d_data_wr_o   = sel ? m1_data_wr_i   : m0_data_wr_i;
  assign mem_d_cacheable_o = sel ? m1_cacheable_i : m0_cacheable_i;
  assign mem_d_req_tag_o   = sel ? m1_req_tag_i   : m0_req_tag_i;
  assign mem_d_rd_o        = req_valid & (sel ? m1_rd_i : m0_rd_i);
  assign mem_d_wr_o        = req_valid ? (sel ? m1_wr_i : m0_wr_i) : 4'b0000;

  assign m0_accept_o = push & ~sel;
  assign m1_accept_o = push & sel;

  assign m0_ack_o      = pop & ~head;
  assign m1_ack_o      = pop & head;
  assign m0_error_o    = pop & ~head & mem_d_error_i;
  assign m1_error_o    = pop & head & mem_d_error_i;
  assign m0_data_rd_o  = mem_d_data_rd_i;
  assign m1_data_rd_o  = mem_d_data_rd_i;
  assign m0_resp_tag_o = mem_d_resp_tag_i;
  assign m1_resp_tag_o = mem_d_resp_tag_i;

  assign unexpected_ack_o = unexp_q;

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    unexp_d   = unexp_q;

    if (push) begin
      lock_d   = 1'b0;
      rr_d     = ~sel;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (req_valid) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (mem_d_ack_i && count_q == '0) begin
      unexp_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      unexp_q   <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      unexp_q   <= unexp_d;
    end
  end

  // Id storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_mem_d_arbiter2.sv
// tb/tb_mem_d_arbiter2.sv - scoreboard bench for mem_d_arbiter2
module tb_mem_d_arbiter2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i;
  logic        m0_rd_i, m1_rd_i, m0_cacheable_i, m1_cacheable_i;
  logic [3:0]  m0_wr_i, m1_wr_i;
  logic [10:0] m0_req_tag_i, m1_req_tag_i;
  logic        m0_accept_o, m0_ack_o, m0_error_o, m1_accept_o, m1_ack_o, m1_error_o;
  logic [31:0] m0_data_rd_o, m1_data_rd_o;
  logic [10:0] m0_resp_tag_o, m1_resp_tag_o;
  logic [31:0] mem_d_addr_o, mem_d_data_wr_o, mem_d_data_rd_i;
  logic        mem_d_rd_o, mem_d_cacheable_o;
  logic [3:0]  mem_d_wr_o;
  logic [10:0] mem_d_req_tag_o, mem_d_resp_tag_i;
  logic        mem_d_accept_i, mem_d_ack_i, mem_d_error_i;
  logic        unexpected_ack_o;

  int checks = 0;
  int errors = 0;
  bit sb[$];
  bit exp_id;

  mem_d_arbiter2 #(.OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_data_wr_i(m0_data_wr_i), .m0_rd_i(m0_rd_i), .m0_wr_i(m0_wr_i),
    .m0_cacheable_i(m0_cacheable_i), .m0_req_tag_i(m0_req_tag_i), .m0_accept_o(m0_accept_o),
    .m0_ack_o(m0_ack_o), .m0_error_o(m0_error_o), .m0_data_rd_o(m0_data_rd_o), .m0_resp_tag_o(m0_resp_tag_o),
    .m1_addr_i(m1_addr_i), .m1_data_wr_i(m1_data_wr_i), .m1_rd_i(m1_rd_i), .m1_wr_i(m1_wr_i),
    .m1_cacheable_i(m1_cacheable_i), .m1_req_tag_i(m1_req_tag_i), .m1_accept_o(m1_accept_o),
    .m1_ack_o(m1_ack_o), .m1_error_o(m1_error_o), .m1_data_rd_o(m1_data_rd_o), .m1_resp_tag_o(m1_resp_tag_o),
    .mem_d_addr_o(mem_d_addr_o), .mem_d_data_wr_o(mem_d_data_wr_o), .mem_d_rd_o(mem_d_rd_o),
    .mem_d_wr_o(mem_d_wr_o), .mem_d_cacheable_o(mem_d_cacheable_o), .mem_d_req_tag_o(mem_d_req_tag_o),
    .mem_d_accept_i(mem_d_accept_i), .mem_d_ack_i(mem_d_ack_i), .mem_d_error_i(mem_d_error_i),
    .mem_d_data_rd_i(mem_d_data_rd_i), .mem_d_resp_tag_i(mem_d_resp_tag_i),
    .unexpected_ack_o(unexpected_ack_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    m0_addr_i = '0; m0_data_wr_i = '0; m0_rd_i = 0; m0_wr_i = '0; m0_cacheable_i = 0; m0_req_tag_i = '0;
    m1_addr_i = '0; m1_data_wr_i = '0; m1_rd_i = 0; m1_wr_i = '0; m1_cacheable_i = 0; m1_req_tag_i = '0;
    mem_d_accept_i = 0; mem_d_ack_i = 0; mem_d_error_i = 0; mem_d_data_rd_i = '0; mem_d_resp_tag_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1;
    clear_inputs();
    sb.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    clear_inputs();
    #1;
    checks++;
    if ({mem_d_rd_o, mem_d_wr_o, m0_accept_o, m1_accept_o, m0_ack_o, m1_ack_o, unexpected_ack_o} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b wr=%h acc=%b%b ack=%b%b unexp=%b want all 0",
               mem_d_rd_o, mem_d_wr_o, m0_accept_o, m1_accept_o, m0_ack_o, m1_ack_o, unexpected_ack_o);
    end
  endtask

  task automatic test_single();
    apply_reset();
    m0_rd_i = 1; m0_addr_i = 32'h8000_0010; m0_req_tag_i = 11'h005; mem_d_accept_i = 1;
    #1;
    checks++;
    if (mem_d_rd_o !== 1'b1 || mem_d_addr_o !== 32'h8000_0010 || m0_accept_o !== 1'b1 || m1_accept_o !== 1'b0) begin
      errors++;
      $display("FAIL single_req got rd=%b addr=%h acc0=%b acc1=%b want 1 80000010 1 0",
               mem_d_rd_o, mem_d_addr_o, m0_accept_o, m1_accept_o);
    end
    checks++;
    if (mem_d_req_tag_o !== 11'h005) begin
      errors++;
      $display("FAIL single_tag got %h want 005", mem_d_req_tag_o);
    end
    sb.push_back(1'b0);
    next_cycle();
    clear_inputs();
    next_cycle();
    mem_d_ack_i = 1; mem_d_data_rd_i = 32'hDEAD_BEEF;
    #1;
    exp_id = sb.pop_front();
    checks++;
    if ({m1_ack_o, m0_ack_o} !== (exp_id ? 2'b10 : 2'b01) || m0_data_rd_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_ack got ack=%b%b data=%h want id %0d data deadbeef", m1_ack_o, m0_ack_o, m0_data_rd_o, exp_id);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_contention();
    apply_reset();
    m0_rd_i = 1; m0_addr_i = 32'h0000_1000;
    m1_rd_i = 1; m1_addr_i = 32'h0000_2000;
    mem_d_accept_i = 1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2) != 0;
      #1;
      checks++;
      if (m0_accept_o !== !exp_id || m1_accept_o !== exp_id ||
          mem_d_addr_o !== (exp_id ? 32'h0000_2000 : 32'h0000_1000)) begin
        errors++;
        $display("FAIL contention_grant%0d got acc=%b%b addr=%h want master %0d", i, m1_accept_o, m0_accept_o, mem_d_addr_o, exp_id);
      end
      sb.push_back(exp_id);
      next_cycle();
    end
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      mem_d_ack_i = 1;
      #1;
      exp_id = sb.pop_front();
      checks++;
      if ({m1_ack_o, m0_ack_o} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_ack%0d got ack=%b%b want master %0d", i, m1_ack_o, m0_ack_o, exp_id);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    apply_reset();
    m1_wr_i = 4'hF; m1_data_wr_i = 32'h1234_5678; m1_addr_i = 32'h0000_3000;
    #1;
    next_cycle();
    m0_rd_i = 1; m0_addr_i = 32'h0000_4000;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (mem_d_wr_o !== 4'hF || mem_d_data_wr_o !== 32'h1234_5678 || mem_d_rd_o !== 1'b0 ||
          m0_accept_o !== 1'b0 || m1_accept_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got wr=%h data=%h rd=%b acc=%b%b want F 12345678 0 00",
                 i, mem_d_wr_o, mem_d_data_wr_o, mem_d_rd_o, m1_accept_o, m0_accept_o);
      end
      next_cycle();
    end
    mem_d_accept_i = 1;
    #1;
    checks++;
    if (m1_accept_o !== 1'b1 || m0_accept_o !== 1'b0 || mem_d_wr_o !== 4'hF) begin
      errors++;
      $display("FAIL stall_release got acc=%b%b wr=%h want 10 F", m1_accept_o, m0_accept_o, mem_d_wr_o);
    end
    sb.push_back(1'b1);
    next_cycle();
    m1_wr_i = 4'h0;
    #1;
    checks++;
    if (m0_accept_o !== 1'b1 || mem_d_rd_o !== 1'b1 || mem_d_addr_o !== 32'h0000_4000) begin
      errors++;
      $display("FAIL stall_next_grant got acc0=%b rd=%b addr=%h want 1 1 00004000", m0_accept_o, mem_d_rd_o, mem_d_addr_o);
    end
    sb.push_back(1'b0);
    next_cycle();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      mem_d_ack_i = 1;
      #1;
      exp_id = sb.pop_front();
      checks++;
      if ({m1_ack_o, m0_ack_o} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL stall_ack%0d got ack=%b%b want master %0d", i, m1_ack_o, m0_ack_o, exp_id);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_full();
    apply_reset();
    m0_rd_i = 1; mem_d_accept_i = 1;
    for (int i = 0; i < 4; i++) begin
      m0_addr_i = 32'h100 + 32'(i * 4);
      #1;
      checks++;
      if (m0_accept_o !== 1'b1) begin
        errors++;
        $display("FAIL full_fill%0d got acc0=%b want 1", i, m0_accept_o);
      end
      sb.push_back(1'b0);
      next_cycle();
    end
    #1;
    checks++;
    if (mem_d_rd_o !== 1'b0 || m0_accept_o !== 1'b0) begin
      errors++;
      $display("FAIL full_gate got rd=%b acc0=%b want 0 0", mem_d_rd_o, m0_accept_o);
    end
    next_cycle();
    mem_d_ack_i = 1; mem_d_error_i = 1;
    #1;
    exp_id = sb.pop_front();
    checks++;
    if ({m1_ack_o, m0_ack_o} !== (exp_id ? 2'b10 : 2'b01) || m0_error_o !== 1'b1 || m1_error_o !== 1'b0 ||
        mem_d_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL full_err_ack got ack=%b%b err=%b%b rd=%b want 01 01 0", m1_ack_o, m0_ack_o, m1_error_o, m0_error_o, mem_d_rd_o);
    end
    next_cycle();
    mem_d_ack_i = 0; mem_d_error_i = 0;
    #1;
    checks++;
    if (mem_d_rd_o !== 1'b1 || m0_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL full_reissue got rd=%b acc0=%b want 1 1", mem_d_rd_o, m0_accept_o);
    end
    sb.push_back(1'b0);
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_push_pop();
    mem_d_ack_i = 1;
    #1;
    exp_id = sb.pop_front();
    checks++;
    if ({m1_ack_o, m0_ack_o} !== (exp_id ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL pp_pre_ack got ack=%b%b want master %0d", m1_ack_o, m0_ack_o, exp_id);
    end
    next_cycle();
    m1_rd_i = 1; mem_d_accept_i = 1;
    #1;
    exp_id = sb.pop_front();
    checks++;
    if ({m1_ack_o, m0_ack_o} !== (exp_id ? 2'b10 : 2'b01) || m1_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL pp_same_cycle got ack=%b%b acc1=%b want master %0d acc1 1", m1_ack_o, m0_ack_o, m1_accept_o, exp_id);
    end
    sb.push_back(1'b1);
    next_cycle();
    m1_rd_i = 0; mem_d_accept_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL pp_drain%0d scoreboard empty, want entry", i);
      end else begin
        exp_id = sb.pop_front();
        checks++;
        if ({m1_ack_o, m0_ack_o} !== (exp_id ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL pp_drain%0d got ack=%b%b want master %0d", i, m1_ack_o, m0_ack_o, exp_id);
        end
      end
      next_cycle();
    end
    #1;
    checks++;
    if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || unexpected_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL empty_ack got ack=%b%b unexp=%b want 00 0", m1_ack_o, m0_ack_o, unexpected_ack_o);
    end
    next_cycle();
    mem_d_ack_i = 0;
    #1;
    checks++;
    if (unexpected_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL unexpected_sticky got %b want 1", unexpected_ack_o);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    checks++;
    if (unexpected_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_unexp_clear got %b want 0", unexpected_ack_o);
    end
    m0_rd_i = 1; mem_d_accept_i = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (m0_accept_o !== 1'b1) begin
        errors++;
        $display("FAIL mid_issue%0d got acc0=%b want 1", i, m0_accept_o);
      end
      next_cycle();
    end
    clear_inputs();
    mem_d_ack_i = 1;
    #1;
    rst_i = 1;
    #1;
    sb.delete();
    checks++;
    if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || mem_d_rd_o !== 1'b0 || unexpected_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got ack=%b%b rd=%b unexp=%b want 00 0 0", m1_ack_o, m0_ack_o, mem_d_rd_o, unexpected_ack_o);
    end
    next_cycle();
    rst_i = 0;
    #1;
    checks++;
    if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_stale_ack got ack=%b%b want 00", m1_ack_o, m0_ack_o);
    end
    next_cycle();
    mem_d_ack_i = 0;
    #1;
    checks++;
    if (unexpected_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_unexpected got %b want 1", unexpected_ack_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_full();
    test_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
